uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer that sits directly upstream of the UART transmitter.
- Accepts bytes written over the UART register interface (TX data address) and queues them in order.
- Presents them one at a time to the transmitter through a valid/ready handshake.
- Lets software write bursts without waiting on each serial frame; exposes full/empty/level status for polling.

Parameters:
DW, 8, data width in bits (one UART character)
DEPTH, 16, number of entries; must be a power of two, minimum 2
AW, 4, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; gates the transmit handshake only
flush  input  1  synchronous clear of all queued data
we  input  1  push strobe from the register interface (TX data address written)
wdata  input  DW  byte to push
full  output  1  high when count == DEPTH
empty  output  1  high when count == 0
count  output  AW+1  number of bytes currently queued, 0..DEPTH
tx_valid  output  1  byte available to transmitter
tx_data  output  DW  byte at head of queue
tx_ready  input  1  transmitter accepts head byte this cycle (idle and starting a frame)
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count cleared to 0.
  - empty=1, full=0, tx_valid=0, ovf=0.
  - tx_data is don't-care.
  - Memory contents are not cleared.
- Storage: circular buffer of DEPTH x DW registers. Pointers are AW bits and wrap from DEPTH-1 to 0. count is a separate AW+1-bit counter.
- Push: occurs when we=1 and full=0.
  - mem[wr_ptr] <= wdata; wr_ptr increments.
  - Push while full is dropped; stored data and pointers are unchanged.
- Pop: occurs when tx_valid=1 and tx_ready=1 on a rising edge; rd_ptr increments.
- Head presentation (first-word-fall-through):
  - tx_data = mem[rd_ptr], combinational from the registered pointer.
  - tx_valid = en & ~empty.
  - tx_data must hold stable while tx_valid=1 and no pop occurs.
- Latency:
  - A byte pushed into an empty FIFO at edge N gives tx_valid=1 from cycle N+1, with tx_data equal to that byte.
  - After a pop at edge N, the next byte is at the head in cycle N+1.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Full boundary:
  - Push is rejected whenever full=1, even if a pop occurs on the same edge.
  - count never exceeds DEPTH.
- Empty boundary: tx_valid=0, so no pop can occur. A push on the empty cycle is accepted normally.
- flush=1 at an edge:
  - Pointers and count cleared; empty=1.
  - Overrides any push or pop on the same edge, so the pushed byte is discarded.
  - ovf cleared.
- en=0:
  - tx_valid forced 0, so no pops.
  - Pushes, flush and status outputs still operate.
  - Re-asserting en presents the current head without loss.
- tx_ready while tx_valid=0 has no effect.
- Reset asserted mid-operation: all queued data is abandoned immediately (asynchronous). The transmitter sees tx_valid drop in the same cycle.
- full, empty and count are derived from the registered count; no combinational path from we or tx_ready.

Optional Feature:
Macro UART_TX_FIFO_OVF_EN.
- Defined:
  - ovf is set on any edge where we=1 and full=1 (rejected push).
  - ovf stays set until flush or rst.
  - A set and a flush on the same edge: flush wins, ovf=0.
- Not defined: ovf is tied to 0 and no overflow logic is built. Port list is unchanged.

Test Plan:
- Reset then single byte: rst pulse, en=1, tx_ready=0, push 0xA5 -> next cycle tx_valid=1, tx_data=0xA5, count=1, empty=0; one tx_ready cycle -> count=0, empty=1, tx_valid=0.
- Ordering and wrap: push 0x00..0x0F (16 bytes) -> full=1, count=16; pop all with tx_ready=1 -> tx_data sequence 0x00..0x0F; push/pop 40 more bytes -> order preserved across pointer wrap.
- Overflow: fill 16 bytes, push 0x77 with full=1 -> dropped; the 16 popped bytes exclude 0x77; with UART_TX_FIFO_OVF_EN defined ovf=1 until flush; without it ovf=0.
- Simultaneous push/pop:
  - count=5, we=1 and pop on the same edge -> count stays 5, new byte appended at tail.
  - full, we=1 and pop on the same edge -> count=15, pushed byte dropped.
- Enable gating: queue 0x11,0x22, en=0, tx_ready=1 for 10 cycles -> tx_valid=0, count=2; en=1 -> tx_data=0x11 popped first.
- Flush and async reset: count=7, flush=1 with we=1 -> count=0, empty=1, byte discarded; refill 3 bytes, assert rst between clock edges -> count=0, tx_valid=0 immediately.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte queue between the UART register interface
// and the serial transmitter. It is a first-word-fall-through circular buffer
// with full/empty/level status for software polling.
//
// Optional feature macro: UART_TX_FIFO_OVF_EN
//   defined   -> ovf is a sticky flag, set by a push attempted while full and
//                cleared by flush or rst
//   undefined -> ovf is tied low and no overflow logic is built
//
// Handshake: tx_valid/tx_ready is strict valid/ready. The head byte is
// transferred on a rising edge where both are high. While tx_valid is high
// and no transfer occurs, tx_data holds stable. tx_valid never depends on
// tx_ready, and tx_ready while tx_valid is low has no effect.
module uart_tx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    output logic          ovf
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Status and handshake are derived only from registered state and en,
    // so there is no combinational path from we or tx_ready.
    always_comb begin
        full     = (count == DEPTH_C);
        empty    = (count == '0);
        tx_valid = en & ~empty;
        tx_data  = mem[rd_ptr];
        push     = we & ~full & ~flush;
        pop      = tx_valid & tx_ready & ~flush;
    end

    // Storage array has no reset; contents survive rst and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and level counter; flush overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky overflow: set by a rejected push, cleared by flush (flush wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
        end else if (we && full) begin
            ovf <= 1'b1;
        end
    end
`else
    // Overflow tracking not built; flag reads as zero.
    always_comb begin
        ovf = 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus for uart_tx_fifo with a byte
// scoreboard and a small level/overflow model.
// Honours UART_TX_FIFO_OVF_EN when computing the expected ovf value.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          flush;
    logic          we;
    logic [DW-1:0] wdata;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          ovf;

    logic [DW-1:0] exp_q[$];
    int            mcount;
    bit            movf;
    int            n_cmp;
    int            n_fail;

    uart_tx_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .we       (we),
        .wdata    (wdata),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .ovf      (ovf)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle with the currently driven inputs. Called 1 time unit
    // after a rising edge; checks the head before the edge and status after.
    task automatic cycle();
        bit push_ok;
        bit pop_ok;
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(en && mcount > 0));
        if (en && mcount > 0) begin
            chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
        end
        push_ok = we && (mcount < DEPTH) && !flush;
        pop_ok  = en && tx_ready && (mcount > 0) && !flush;
`ifdef UART_TX_FIFO_OVF_EN
        if (flush) movf = 1'b0;
        else if (we && mcount == DEPTH) movf = 1'b1;
`else
        movf = 1'b0;
`endif
        if (flush) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (pop_ok) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(wdata);
            mcount = mcount + int'(push_ok) - int'(pop_ok);
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(mcount));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("ovf", 32'(ovf), 32'(movf));
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        we    = 1'b1;
        wdata = b;
        cycle();
        we    = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && mcount > 0; k++) cycle();
        tx_ready = 1'b0;
        chk("drain_empty", 32'(empty), 32'(1));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; mcount = 0; movf = 1'b0;
        rst = 1'b1; en = 1'b1; flush = 1'b0; we = 1'b0; wdata = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // single byte: visible the cycle after the push, gone after one pop
        push_byte(8'hA5);
        chk("single_valid", 32'(tx_valid), 32'(1));
        chk("single_data", 32'(tx_data), 32'(8'hA5));
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        chk("single_popped_valid", 32'(tx_valid), 32'(0));

        // fill 0x00..0x0F, then an overflowing push of 0x77
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'(1));
        push_byte(8'h77);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        drain();

        // 40 bytes straight through with push and pop overlapping (wraps pointers)
        tx_ready = 1'b1;
        for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)));
        drain();

        // random mix of pushes and pops
        for (int i = 0; i < 80; i++) begin
            we       = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
            wdata    = 8'($urandom_range(0, 255));
            cycle();
        end
        we = 1'b0;
        drain();

        // push and pop on the same edge at count 5
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        tx_ready = 1'b1;
        push_byte(8'hC5);
        tx_ready = 1'b0;
        chk("simul5_count", 32'(count), 32'(5));
        drain();

        // push and pop on the same edge while full: push rejected
        for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
        tx_ready = 1'b1;
        push_byte(8'hEE);
        tx_ready = 1'b0;
        chk("simulfull_count", 32'(count), 32'(DEPTH - 1));
        drain();

        // flush clears ovf (if built) and empties the queue
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_ovf", 32'(ovf), 32'(0));

        // enable gating
        push_byte(8'h11);
        push_byte(8'h22);
        en = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("gate_count", 32'(count), 32'(2));
        en = 1'b1;
        cycle();
        chk("gate_next", 32'(tx_data), 32'(8'h22));
        drain();

        // flush with a concurrent push: byte discarded
        for (int i = 0; i < 7; i++) push_byte(8'h30 + 8'(i));
        flush = 1'b1;
        push_byte(8'hDD);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_valid", 32'(tx_valid), 32'(0));

        // asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_valid", 32'(tx_valid), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        exp_q.delete();
        mcount = 0;
        movf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        push_byte(8'h5A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
